// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC arbiter types, constants and round-robin search helper
package noc_pkg;

  localparam int NOC_NUM_PORTS = 5;

  // Largest port count the search helper handles; slices pad their vectors up to this.
  localparam int NOC_MAX_PORTS = 16;
  localparam int NOC_IDX_W     = 4;

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_S = 3'd1,
    PORT_E = 3'd2,
    PORT_W = 3'd3,
    PORT_L = 3'd4
  } noc_port_e;

  typedef struct packed {
    logic                 valid;
    logic [NOC_IDX_W-1:0] idx;
  } rr_pick_t;

  // First requester at or after ptr, wrapping modulo num_ports.
  // ptr < num_ports and k < num_ports, so a single subtract performs the wrap.
  function automatic rr_pick_t rr_pick(input logic [NOC_MAX_PORTS-1:0] req_vec,
                                       input logic [NOC_IDX_W-1:0]     ptr,
                                       input int                       num_ports);
    rr_pick_t res;
    int       cand;
    res = '0;
    for (int k = 0; k < NOC_MAX_PORTS; k++) begin
      if (k < num_ports && !res.valid) begin
        cand = int'(ptr) + k;
        if (cand >= num_ports) cand = cand - num_ports;
        if (req_vec[cand]) begin
          res.valid = 1'b1;
          res.idx   = cand[NOC_IDX_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/noc_rr_arbiter_if.sv
// rtl/noc_rr_arbiter_if.sv - request/grant bundle between input buffers, arbiter and crossbar
interface noc_rr_arbiter_if #(
  parameter int NUM_PORTS = 5,
  parameter int PORT_W    = $clog2(NUM_PORTS)
);
  logic [NUM_PORTS-1:0]           req_i;
  logic [NUM_PORTS*PORT_W-1:0]    dest_i;
  logic [NUM_PORTS-1:0]           tail_i;
  logic [NUM_PORTS-1:0]           out_ready_i;
  logic [NUM_PORTS*NUM_PORTS-1:0] gnt_o;
  logic [NUM_PORTS-1:0]           in_ack_o;
  logic [NUM_PORTS-1:0]           busy_o;

  // Buffers/crossbar side: presents flits and output readiness, consumes grants.
  modport master (
    output req_i, dest_i, tail_i, out_ready_i,
    input  gnt_o, in_ack_o, busy_o
  );

  // Arbiter side.
  modport slave (
    input  req_i, dest_i, tail_i, out_ready_i,
    output gnt_o, in_ack_o, busy_o
  );
endinterface

// File: rtl/noc_rr_slice.sv
// rtl/noc_rr_slice.sv - one output's round-robin pointer, wormhole lock (NOC_ARB_WORMHOLE_LOCK_EN) and search
module noc_rr_slice
  import noc_pkg::*;
#(
  parameter int NUM_PORTS = 5,
  parameter int PORT_W    = $clog2(NUM_PORTS),
  parameter int OUT_IDX   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [NUM_PORTS-1:0] i_tail,
  input  logic                 i_ready,
  output logic [NUM_PORTS-1:0] o_gnt,
  output logic [NUM_PORTS-1:0] o_xfer,
  output logic                 o_busy
);

  // Staggered start so that outputs do not all favour the same input after reset.
  localparam logic [PORT_W-1:0] RST_PTR = PORT_W'((OUT_IDX + 1) % NUM_PORTS);

  logic [PORT_W-1:0]        r_ptr;
  logic [NOC_MAX_PORTS-1:0] w_req_pad;
  logic [NOC_IDX_W-1:0]     w_ptr_pad;
  rr_pick_t                 w_pick;
  logic                     w_valid;
  logic [PORT_W-1:0]        w_win;
  logic [PORT_W-1:0]        w_next;
  logic                     w_xfer_any;
  logic                     w_unused;

  // Round-robin search among requesters starting at the pointer.
  always_comb begin
    w_req_pad                = '0;
    w_req_pad[NUM_PORTS-1:0] = i_req;
    w_ptr_pad                = '0;
    w_ptr_pad[PORT_W-1:0]    = r_ptr;
    w_pick                   = rr_pick(w_req_pad, w_ptr_pad, NUM_PORTS);
  end

`ifdef NOC_ARB_WORMHOLE_LOCK_EN
  logic              r_lock;
  logic [PORT_W-1:0] r_owner;

  // While locked only the packet owner may proceed; a missing owner flit stalls the output.
  always_comb begin
    if (r_lock) begin
      w_win   = r_owner;
      w_valid = i_req[r_owner];
    end else begin
      w_win   = w_pick.idx[PORT_W-1:0];
      w_valid = w_pick.valid;
    end
  end

  // Lock on a non-tail transfer; release and rotate past the winner on the tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= RST_PTR;
      r_lock  <= 1'b0;
      r_owner <= '0;
    end else if (w_xfer_any) begin
      if (i_tail[w_win]) begin
        r_lock <= 1'b0;
        r_ptr  <= w_next;
      end else begin
        r_lock  <= 1'b1;
        r_owner <= w_win;
      end
    end
  end

  assign o_busy   = r_lock;
  assign w_unused = ^w_pick.idx;
`else
  // Without locking every flit arbitrates on its own.
  always_comb begin
    w_win   = w_pick.idx[PORT_W-1:0];
    w_valid = w_pick.valid;
  end

  // Rotate past the winner on every transfer, so competing packets interleave per flit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= RST_PTR;
    end else if (w_xfer_any) begin
      r_ptr <= w_next;
    end
  end

  assign o_busy   = 1'b0;
  assign w_unused = ^{w_pick.idx, i_tail};
`endif

  // Next pointer wraps from the last input back to input 0.
  always_comb begin
    w_next = (w_win == PORT_W'(NUM_PORTS - 1)) ? '0 : w_win + 1'b1;
  end

  // One-hot grant; back-pressure keeps the grant but suppresses the transfer.
  always_comb begin
    o_gnt = '0;
    if (w_valid) o_gnt[w_win] = 1'b1;
    o_xfer     = o_gnt & {NUM_PORTS{i_ready}};
    w_xfer_any = w_valid & i_ready;
  end

endmodule

// File: rtl/noc_rr_arbiter.sv
// rtl/noc_rr_arbiter.sv - per-output round-robin router arbiter, wormhole lock under NOC_ARB_WORMHOLE_LOCK_EN
module noc_rr_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_PORTS = NOC_NUM_PORTS,
  parameter int PORT_W    = $clog2(NUM_PORTS)
) (
  input logic            clk,
  input logic            rst,
  noc_rr_arbiter_if.slave bus
);

  logic [NUM_PORTS-1:0] w_req_mat [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_gnt     [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_xfer    [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_busy;
  logic [NUM_PORTS-1:0] w_ack;

  // Decode destinations into a per-output request vector; out-of-range indices match nothing.
  always_comb begin
    w_req_mat = '{default: '0};
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        w_req_mat[o][i] = bus.req_i[i] &&
                          (bus.dest_i[i*PORT_W +: PORT_W] == PORT_W'(o));
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    noc_rr_slice #(
      .NUM_PORTS (NUM_PORTS),
      .PORT_W    (PORT_W),
      .OUT_IDX   (o)
    ) u_slice (
      .clk     (clk),
      .rst     (rst),
      .i_req   (w_req_mat[o]),
      .i_tail  (bus.tail_i),
      .i_ready (bus.out_ready_i[o]),
      .o_gnt   (w_gnt[o]),
      .o_xfer  (w_xfer[o]),
      .o_busy  (w_busy[o])
    );

    assign bus.gnt_o[o*NUM_PORTS +: NUM_PORTS] = w_gnt[o];
  end

  // An input targets at most one output, so ORing the per-output transfers gives its pop.
  always_comb begin
    w_ack = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_ack = w_ack | w_xfer[o];
    end
  end

  assign bus.in_ack_o = w_ack;
  assign bus.busy_o   = w_busy;

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// tb/tb_noc_rr_arbiter.sv - directed self-checking bench for noc_rr_arbiter (both NOC_ARB_WORMHOLE_LOCK_EN builds)
module tb_noc_rr_arbiter;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  noc_rr_arbiter_if #(.NUM_PORTS(5)) u_if ();

  noc_rr_arbiter #(.NUM_PORTS(5)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    u_if.req_i       = '0;
    u_if.dest_i      = '0;
    u_if.tail_i      = '0;
    u_if.out_ready_i = 5'b11111;
  endtask

  task automatic set_dest(input int i, input int d);
    u_if.dest_i[i*3 +: 3] = 3'(d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    total++; if (u_if.gnt_o !== 25'd0) begin bad++; $display("FAIL reset_gnt: got %h want 0", u_if.gnt_o); end
    total++; if (u_if.in_ack_o !== 5'd0) begin bad++; $display("FAIL reset_ack: got %b want 00000", u_if.in_ack_o); end
    total++; if (u_if.busy_o !== 5'd0) begin bad++; $display("FAIL reset_busy: got %b want 00000", u_if.busy_o); end
  endtask

  task automatic test_staggered();
    logic [4:0]  exp_ack [3];
    logic [4:0]  pend;
    logic [24:0] exp_gnt;
    exp_ack = '{5'b01000, 5'b00001, 5'b00100};
    do_reset();
    set_dest(0, 2); set_dest(2, 2); set_dest(3, 2);
    u_if.tail_i = 5'b11111;
    pend = 5'b01101;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      u_if.req_i = pend;
      #2;
      exp_gnt = 25'(exp_ack[c]) << 10;
      total++; if (u_if.in_ack_o !== exp_ack[c]) begin bad++; $display("FAIL stag_ack c%0d: got %b want %b", c, u_if.in_ack_o, exp_ack[c]); end
      total++; if (u_if.gnt_o !== exp_gnt) begin bad++; $display("FAIL stag_gnt c%0d: got %h want %h", c, u_if.gnt_o, exp_gnt); end
      pend = pend & ~exp_ack[c];
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_wormhole();
    logic [4:0] exp_ack  [4];
    logic [4:0] exp_busy [4];
    logic [4:0] r;
    logic [4:0] t;
    int         flit1;
    logic       pend4;
`ifdef NOC_ARB_WORMHOLE_LOCK_EN
    exp_ack  = '{5'b00010, 5'b00010, 5'b00010, 5'b10000};
    exp_busy = '{5'b00000, 5'b00001, 5'b00001, 5'b00000};
`else
    exp_ack  = '{5'b00010, 5'b10000, 5'b00010, 5'b00010};
    exp_busy = '{5'b00000, 5'b00000, 5'b00000, 5'b00000};
`endif
    do_reset();
    set_dest(1, 0); set_dest(4, 0);
    flit1 = 0;
    pend4 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      r = '0; t = '0;
      r[1] = (flit1 < 3);
      t[1] = (flit1 == 2);
      r[4] = pend4;
      t[4] = 1'b1;
      u_if.req_i  = r;
      u_if.tail_i = t;
      #2;
      total++; if (u_if.in_ack_o !== exp_ack[c]) begin bad++; $display("FAIL worm_ack c%0d: got %b want %b", c, u_if.in_ack_o, exp_ack[c]); end
      total++; if (u_if.busy_o !== exp_busy[c]) begin bad++; $display("FAIL worm_busy c%0d: got %b want %b", c, u_if.busy_o, exp_busy[c]); end
      if (exp_ack[c][1]) flit1++;
      if (exp_ack[c][4]) pend4 = 1'b0;
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_back_pressure();
    do_reset();
    set_dest(2, 4);
    u_if.tail_i      = 5'b11111;
    u_if.out_ready_i = 5'b01111;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      u_if.req_i = 5'b00100;
      #2;
      total++; if (u_if.gnt_o !== (25'd1 << 22)) begin bad++; $display("FAIL bp_gnt c%0d: got %h want %h", c, u_if.gnt_o, 25'd1 << 22); end
      total++; if (u_if.in_ack_o !== 5'b00000) begin bad++; $display("FAIL bp_ack c%0d: got %b want 00000", c, u_if.in_ack_o); end
    end
    @(negedge clk);
    u_if.out_ready_i = 5'b11111;
    #2;
    total++; if (u_if.in_ack_o !== 5'b00100) begin bad++; $display("FAIL bp_release_ack: got %b want 00100", u_if.in_ack_o); end
    // ptr[4] moved from 0 to 3 only on the real transfer: input 4 now beats input 0.
    @(negedge clk);
    set_dest(0, 4); set_dest(4, 4);
    u_if.req_i = 5'b10001;
    #2;
    total++; if (u_if.in_ack_o !== 5'b10000) begin bad++; $display("FAIL bp_ptr_after: got %b want 10000", u_if.in_ack_o); end
    @(negedge clk);
    u_if.req_i = 5'b00001;
    #2;
    total++; if (u_if.in_ack_o !== 5'b00001) begin bad++; $display("FAIL bp_ptr_wrap: got %b want 00001", u_if.in_ack_o); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_permutation();
    do_reset();
    for (int i = 0; i < 5; i++) set_dest(i, 4 - i);
    u_if.tail_i = 5'b11111;
    @(negedge clk);
    u_if.req_i = 5'b11111;
    #2;
    total++; if (u_if.in_ack_o !== 5'b11111) begin bad++; $display("FAIL perm_ack: got %b want 11111", u_if.in_ack_o); end
    total++; if (u_if.gnt_o !== 25'h0111110) begin bad++; $display("FAIL perm_gnt: got %h want 0111110", u_if.gnt_o); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_illegal_dest();
    do_reset();
    set_dest(3, 6);
    u_if.tail_i = 5'b11111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      u_if.req_i = 5'b01000;
      #2;
      total++; if (u_if.gnt_o !== 25'd0) begin bad++; $display("FAIL illegal_gnt c%0d: got %h want 0", c, u_if.gnt_o); end
      total++; if (u_if.in_ack_o !== 5'd0) begin bad++; $display("FAIL illegal_ack c%0d: got %b want 00000", c, u_if.in_ack_o); end
    end
    @(negedge clk);
    set_dest(3, 5); set_dest(0, 1);
    u_if.req_i = 5'b01001;
    #2;
    total++; if (u_if.in_ack_o !== 5'b00001) begin bad++; $display("FAIL illegal_mixed_ack: got %b want 00001", u_if.in_ack_o); end
    total++; if (u_if.gnt_o !== (25'd1 << 5)) begin bad++; $display("FAIL illegal_mixed_gnt: got %h want %h", u_if.gnt_o, 25'd1 << 5); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset_mid_packet();
    logic [4:0] exp_busy_pre;
    logic [4:0] exp_last;
`ifdef NOC_ARB_WORMHOLE_LOCK_EN
    exp_busy_pre = 5'b00001;
    exp_last     = 5'b00010;
`else
    exp_busy_pre = 5'b00000;
    exp_last     = 5'b00001;
`endif
    do_reset();
    set_dest(0, 0); set_dest(1, 0);
    u_if.tail_i = 5'b00001;
    @(negedge clk);
    u_if.req_i = 5'b00010;
    #2;
    total++; if (u_if.in_ack_o !== 5'b00010) begin bad++; $display("FAIL rmid_first_ack: got %b want 00010", u_if.in_ack_o); end
    @(negedge clk);
    rst              = 1'b1;
    u_if.out_ready_i = 5'b00000;
    #2;
    total++; if (u_if.busy_o !== exp_busy_pre) begin bad++; $display("FAIL rmid_busy_pre: got %b want %b", u_if.busy_o, exp_busy_pre); end
    @(negedge clk);
    rst              = 1'b0;
    u_if.out_ready_i = 5'b11111;
    u_if.req_i       = 5'b00011;
    #2;
    total++; if (u_if.busy_o !== 5'b00000) begin bad++; $display("FAIL rmid_busy_post: got %b want 00000", u_if.busy_o); end
    total++; if (u_if.in_ack_o !== 5'b00010) begin bad++; $display("FAIL rmid_ptr_reset: got %b want 00010", u_if.in_ack_o); end
    @(negedge clk);
    u_if.tail_i = 5'b00011;
    #2;
    total++; if (u_if.in_ack_o !== exp_last) begin bad++; $display("FAIL rmid_after: got %b want %b", u_if.in_ack_o, exp_last); end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_staggered();
    test_wormhole();
    test_back_pressure();
    test_permutation();
    test_illegal_dest();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
